sensor_read_scheduler: RTL and testbench
========================================

# sensor_read_scheduler

Sequences the DHT11 decoder on behalf of a host-side requester (UART/command layer). It accepts one read request at a time and enforces the sensor's minimum re-trigger interval. It pulses the decoder's start, waits for its busy (`hold`) window, validates the frame (checksum, all-zero error frame) and retries on failure. It returns a 32-bit reading plus status over a valid/ready response channel.

## Interface
Clock `clock`, reset `reset`: synchronous, active-high.

**Parameters**
- `MIN_INTERVAL` (default 100_000_000): minimum cycles between decoder starts (2 s @ 50 MHz).
- `TIMEOUT` (default 20_000_000): max cycles from start pulse to `dec_hold` falling.
- `ARM_WINDOW` (default 8): max cycles from start pulse to `dec_hold` rising.
- `MAX_ATTEMPTS` (default 3): decoder starts per request, range 1..15.

**Ports**
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: read request.
- `req_ready` out 1: high only in IDLE.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_data` out 32: {hum_int, hum_float, temp_int, temp_float}.
- `rsp_status` out 2: 00 ok, 01 checksum fail, 10 timeout, 11 sensor error.
- `rsp_cached` out 1: response served from cache (0 when the cache is compiled out).
- `dec_enable` out 1: decoder enable.
- `dec_reset` out 1: decoder start pulse.
- `dec_hold` in 1: decoder busy.
- `dec_error` in 1: decoder error flag.
- `dec_hum_int`, `dec_hum_float`, `dec_temp_int`, `dec_temp_float`, `dec_checksum` in 8 each: decoder bytes.

## Operation
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_status`=00, `rsp_cached`=0, `dec_reset`=0, `dec_enable`=0.
  - Interval counter saturated, so the first request starts immediately.
  - Attempt counter 0; state IDLE.
- `dec_enable`=1 from the first cycle after reset deassertion onward.
- Interval counter: cleared on each start pulse, increments to and saturates at `MIN_INTERVAL`.

**States**
- IDLE: `req_ready`=1. On accept, attempts←0. Go to START if the interval has elapsed, else GUARD.
- GUARD: wait until the interval counter = `MIN_INTERVAL`, then START.
- START: `dec_reset`=1 for exactly one cycle, attempts+1, timeout counter←0, go to ARM.
- ARM: wait for `dec_hold`=1 and go to BUSY. After `ARM_WINDOW` cycles without it, fail with status 10.
- BUSY: wait for `dec_hold` 1→0. Latch the five bytes and `dec_error` on the cycle `dec_hold` is first seen low, then go to CHECK. Timeout counter reaching `TIMEOUT` fails with status 10.
- CHECK, classified in priority order:
  1. Latched `dec_error`=1, or the 40-bit frame is all zero → status 11.
  2. Otherwise, (sum of the four data bytes) mod 256 ≠ checksum → status 01.
  3. Otherwise ok.
- On ok: load the response and cache, go to RESPOND.
- On failure: if attempts < `MAX_ATTEMPTS`, go to GUARD (retry); else load `rsp_data`=0 with the failure status and go to RESPOND.
- RESPOND: `rsp_valid`=1, outputs stable until `rsp_valid && rsp_ready`, then IDLE.
- Status on final failure is that of the last attempt.
- `dec_hold` transitions outside ARM/BUSY are ignored.
- Reset mid-operation: return to reset values next cycle. An in-flight response is dropped. The decoder is not restarted until a new request arrives.

## Timing
- Accept (IDLE, interval elapsed) → `dec_reset` high on the next cycle.
- Decoder fall of `dec_hold` → `rsp_valid` 2 cycles later (BUSY→CHECK→RESPOND) on success.
- Back-to-back requests: consecutive `dec_reset` pulses are never closer than `MIN_INTERVAL` cycles, including retries.
- `req_valid` is ignored outside IDLE. A response may be consumed in its first valid cycle; `req_ready` returns the cycle after.

## Configuration
- `SENSOR_CACHE_EN` defined:
  - A request accepted while the interval has not elapsed, with a valid cached ok reading, is answered without starting the decoder.
  - The response is the cached data, status 00, `rsp_cached`=1, with `rsp_valid` one cycle after accept.
  - With no valid cache entry, the request goes to GUARD.
  - The cache is invalidated by reset only.
- `SENSOR_CACHE_EN` undefined:
  - No cache storage; `rsp_cached` tied 0.
  - An early request always waits in GUARD.

## Test plan
Bench params: `MIN_INTERVAL`=1000, `TIMEOUT`=500, `ARM_WINDOW`=8, `MAX_ATTEMPTS`=3. Behavioural decoder model.

1. Request after reset; model holds `hold` 100 cycles, returns bytes 0x37,0x00,0x18,0x00,chk 0x4F → one `dec_reset` pulse, `rsp_data`=0x37001800, status 00.
2. Model returns checksum 0x50 every time → 3 starts spaced ≥1000 cycles, final status 01, `rsp_data`=0.
3. Model never raises `hold` → status 10 after 3 attempts, each ARM failure 8 cycles after its start pulse.
4. First attempt all-zero frame with `dec_error`=0, second attempt good → status 00 after 2 starts.
5. Second request 200 cycles after a good response → with `SENSOR_CACHE_EN`, immediate cached reply, `rsp_cached`=1, no `dec_reset`; without it, `dec_reset` 1000 cycles after the prior start.
6. `reset` asserted while in BUSY, then `rsp_ready` held 0 in RESPOND → after reset all outputs at reset values; in RESPOND, data stable across 50 stalled cycles.

Source files
------------

// File: rtl/sensor_read_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sensor_read_scheduler: DHT11 read sequencer with re-trigger guard and retry;
// define SENSOR_CACHE_EN to answer early requests from the last ok reading. Rev 1.0
// ---------------------------------------------------------------------------
module sensor_read_scheduler #(
   parameter int MIN_INTERVAL = 100_000_000,
   parameter int TIMEOUT      = 20_000_000,
   parameter int ARM_WINDOW   = 8,
   parameter int MAX_ATTEMPTS = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_status,
   output logic        rsp_cached,
   output logic        dec_enable,
   output logic        dec_reset,
   input  logic        dec_hold,
   input  logic        dec_error,
   input  logic [7:0]  dec_hum_int,
   input  logic [7:0]  dec_hum_float,
   input  logic [7:0]  dec_temp_int,
   input  logic [7:0]  dec_temp_float,
   input  logic [7:0]  dec_checksum
);
   localparam int c_int_w   = $clog2(MIN_INTERVAL + 1);
   localparam int c_tmo_max = (TIMEOUT > ARM_WINDOW) ? TIMEOUT : ARM_WINDOW;
   localparam int c_tmo_w   = $clog2(c_tmo_max + 1);

   localparam logic [c_int_w-1:0] c_min_interval = c_int_w'(MIN_INTERVAL);
   localparam logic [c_tmo_w-1:0] c_arm_last     = c_tmo_w'(ARM_WINDOW - 1);
   localparam logic [c_tmo_w-1:0] c_tmo_last     = c_tmo_w'(TIMEOUT - 1);
   localparam logic [3:0]         c_max_attempts = 4'(MAX_ATTEMPTS);

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_CHK = 2'b01;
   localparam logic [1:0] ST_TMO = 2'b10;
   localparam logic [1:0] ST_ERR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GUARD   = 3'd1,
      S_START   = 3'd2,
      S_ARM     = 3'd3,
      S_BUSY    = 3'd4,
      S_CHECK   = 3'd5,
      S_RESPOND = 3'd6
   } state_t;

   state_t              state_q;
   logic [c_int_w-1:0]  interval_q;
   logic [c_tmo_w-1:0]  tmo_q;
   logic [3:0]          attempts_q;
   logic [31:0]         frame_q;
   logic [7:0]          chk_q;
   logic                err_q;
   logic [31:0]         rsp_data_q;
   logic [1:0]          rsp_status_q;
   logic                dec_reset_q;
   logic                dec_enable_q;

   logic                interval_done;
   logic                accept;
   logic                start_d;
   logic                fail_d;
   logic [1:0]          fail_status_d;
   logic [1:0]          check_status;
   logic [7:0]          data_sum;

`ifdef SENSOR_CACHE_EN
   logic                cache_valid_q;
   logic [31:0]         cache_data_q;
   logic                rsp_cached_q;
   assign rsp_cached = rsp_cached_q;
`else
   assign rsp_cached = 1'b0;
`endif

   assign interval_done = (interval_q == c_min_interval);
   assign req_ready     = (state_q == S_IDLE) && dec_enable_q;
   assign accept        = req_valid && req_ready;
   // Interval restarts on the cycle the pulse is scheduled, so pulses never crowd closer than MIN_INTERVAL.
   assign start_d       = interval_done && (accept || (state_q == S_GUARD));
   assign rsp_valid     = (state_q == S_RESPOND);
   assign rsp_data      = rsp_data_q;
   assign rsp_status    = rsp_status_q;
   assign dec_reset     = dec_reset_q;
   assign dec_enable    = dec_enable_q;
   assign data_sum      = frame_q[31:24] + frame_q[23:16] + frame_q[15:8] + frame_q[7:0];

   always_comb begin
      check_status = ST_OK;
      if (err_q || ({frame_q, chk_q} == 40'd0)) begin
         check_status = ST_ERR;
      end else if (data_sum != chk_q) begin
         check_status = ST_CHK;
      end
   end

   always_comb begin
      fail_d        = 1'b0;
      fail_status_d = ST_TMO;
      case (state_q)
         S_ARM:   fail_d = !dec_hold && (tmo_q >= c_arm_last);
         S_BUSY:  fail_d = dec_hold && (tmo_q >= c_tmo_last);
         S_CHECK: begin
            fail_d        = (check_status != ST_OK);
            fail_status_d = check_status;
         end
         default: fail_d = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         interval_q <= c_min_interval;
      end else if (start_d) begin
         interval_q <= '0;
      end else if (!interval_done) begin
         interval_q <= interval_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         tmo_q        <= '0;
         attempts_q   <= '0;
         frame_q      <= '0;
         chk_q        <= '0;
         err_q        <= 1'b0;
         rsp_data_q   <= '0;
         rsp_status_q <= ST_OK;
         dec_reset_q  <= 1'b0;
         dec_enable_q <= 1'b0;
`ifdef SENSOR_CACHE_EN
         cache_valid_q <= 1'b0;
         cache_data_q  <= '0;
         rsp_cached_q  <= 1'b0;
`endif
      end else begin
         dec_enable_q <= 1'b1;
         dec_reset_q  <= start_d;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  attempts_q <= '0;
                  if (interval_done) begin
                     state_q <= S_START;
                  end
`ifdef SENSOR_CACHE_EN
                  else if (cache_valid_q) begin
                     rsp_data_q   <= cache_data_q;
                     rsp_status_q <= ST_OK;
                     rsp_cached_q <= 1'b1;
                     state_q      <= S_RESPOND;
                  end
`endif
                  else begin
                     state_q <= S_GUARD;
                  end
               end
            end
            S_GUARD: begin
               if (interval_done) state_q <= S_START;
            end
            S_START: begin
               attempts_q <= attempts_q + 4'd1;
               tmo_q      <= '0;
               state_q    <= S_ARM;
            end
            S_ARM: begin
               tmo_q <= tmo_q + 1'b1;
               if (dec_hold) state_q <= S_BUSY;
            end
            S_BUSY: begin
               tmo_q <= tmo_q + 1'b1;
               if (!dec_hold) begin
                  frame_q <= {dec_hum_int, dec_hum_float, dec_temp_int, dec_temp_float};
                  chk_q   <= dec_checksum;
                  err_q   <= dec_error;
                  state_q <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (check_status == ST_OK) begin
                  rsp_data_q   <= frame_q;
                  rsp_status_q <= ST_OK;
                  state_q      <= S_RESPOND;
`ifdef SENSOR_CACHE_EN
                  rsp_cached_q  <= 1'b0;
                  cache_valid_q <= 1'b1;
                  cache_data_q  <= frame_q;
`endif
               end
            end
            S_RESPOND: begin
               if (rsp_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         // Any failed attempt either retries through the guard or reports the last status.
         if (fail_d) begin
            if (attempts_q < c_max_attempts) begin
               state_q <= S_GUARD;
            end else begin
               rsp_data_q   <= '0;
               rsp_status_q <= fail_status_d;
               state_q      <= S_RESPOND;
`ifdef SENSOR_CACHE_EN
               rsp_cached_q <= 1'b0;
`endif
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_sensor_read_scheduler.sv
`default_nettype none
// tb_sensor_read_scheduler: directed bench driving the scheduler against a behavioural DHT11 decoder.
module tb_sensor_read_scheduler;
   localparam int MIN_INTERVAL = 1000;
   localparam int TIMEOUT      = 500;
   localparam int ARM_WINDOW   = 8;
   localparam int MAX_ATTEMPTS = 3;
   localparam int HOLD_LEN     = 100;
   localparam logic [1:0] M_GOOD = 2'd0, M_BADCHK = 2'd1, M_NOHOLD = 2'd2, M_ZERO = 2'd3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_status;
   logic        rsp_cached;
   logic        dec_enable;
   logic        dec_reset;
   logic        dec_hold = 1'b0;
   logic        dec_error = 1'b0;
   logic [7:0]  dec_hum_int = 8'd0, dec_hum_float = 8'd0, dec_temp_int = 8'd0;
   logic [7:0]  dec_temp_float = 8'd0, dec_checksum = 8'd0;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          pulse_q[$];
   int          base_idx = 0;
   int          fall_cyc = 0;
   bit          model_busy = 1'b0;
   logic [1:0]  mode_tbl [0:3];

   sensor_read_scheduler #(
      .MIN_INTERVAL(MIN_INTERVAL),
      .TIMEOUT(TIMEOUT),
      .ARM_WINDOW(ARM_WINDOW),
      .MAX_ATTEMPTS(MAX_ATTEMPTS)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_status(rsp_status), .rsp_cached(rsp_cached),
      .dec_enable(dec_enable), .dec_reset(dec_reset),
      .dec_hold(dec_hold), .dec_error(dec_error),
      .dec_hum_int(dec_hum_int), .dec_hum_float(dec_hum_float),
      .dec_temp_int(dec_temp_int), .dec_temp_float(dec_temp_float),
      .dec_checksum(dec_checksum)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic set_modes(input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2);
      mode_tbl[0] = m0;
      mode_tbl[1] = m1;
      mode_tbl[2] = m2;
      mode_tbl[3] = m2;
      base_idx    = pulse_q.size();
   endtask

   task automatic request(input int budget, input bit consume, output logic [31:0] data,
                          output logic [1:0] st, output logic cached, output int acc_c,
                          output int rsp_c, output bit seen);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 100) begin tick(); n++; end
      req_valid = 1'b1;
      acc_c     = cyc;
      tick();
      req_valid = 1'b0;
      n = 0;
      while (rsp_valid !== 1'b1 && n < budget) begin tick(); n++; end
      seen   = (rsp_valid === 1'b1);
      data   = rsp_data;
      st     = rsp_status;
      cached = rsp_cached;
      rsp_c  = cyc;
      if (consume) begin
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
      end
   endtask

   // Decoder model: hold rises two cycles after the start pulse, lasts HOLD_LEN cycles, then bytes appear.
   initial begin : decoder_model
      int k;
      logic [1:0] mode;
      forever begin
         @(posedge clock);
         #1;
         if (dec_reset === 1'b1) begin
            k = pulse_q.size() - base_idx;
            if (k > 3) k = 3;
            if (k < 0) k = 0;
            mode = mode_tbl[k];
            pulse_q.push_back(cyc);
            if (mode != M_NOHOLD) begin
               model_busy = 1'b1;
               repeat (2) begin @(posedge clock); #1; end
               dec_hold = 1'b1;
               repeat (HOLD_LEN) begin @(posedge clock); #1; end
               case (mode)
                  M_ZERO:   {dec_hum_int, dec_hum_float, dec_temp_int, dec_temp_float, dec_checksum} = 40'h00_00_00_00_00;
                  M_BADCHK: {dec_hum_int, dec_hum_float, dec_temp_int, dec_temp_float, dec_checksum} = 40'h37_00_18_00_50;
                  default:  {dec_hum_int, dec_hum_float, dec_temp_int, dec_temp_float, dec_checksum} = 40'h37_00_18_00_4F;
               endcase
               dec_error  = 1'b0;
               dec_hold   = 1'b0;
               fall_cyc   = cyc;
               model_busy = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
      $fatal(1);
   end

   initial begin : main
      logic [31:0] d;
      logic [1:0]  st;
      logic        ca;
      int          acc, rc, n, g0, g1, prev, n0, bad;
      bit          seen;

      set_modes(M_GOOD, M_GOOD, M_GOOD);
      repeat (3) tick();
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_status", rsp_status, 0);
      check("rst_rsp_cached", rsp_cached, 0);
      check("rst_dec_reset", dec_reset, 0);
      check("rst_dec_enable", dec_enable, 0);
      reset = 1'b0;
      tick();
      check("post_rst_enable", dec_enable, 1);

      // 1: single good read straight after reset
      set_modes(M_GOOD, M_GOOD, M_GOOD);
      request(5000, 1'b1, d, st, ca, acc, rc, seen);
      n = pulse_q.size() - base_idx;
      check("t1_seen", seen, 1);
      check("t1_data", d, 32'h37001800);
      check("t1_status", st, 2'b00);
      check("t1_cached", ca, 0);
      check("t1_starts", n, 1);
      check("t1_start_latency", (n >= 1) ? pulse_q[base_idx] - acc : -1, 1);
      check("t1_rsp_after_fall", rc - fall_cyc, 2);
      check("t1_ready_after_rsp", req_ready, 1);

      // 2: checksum always wrong
      repeat (MIN_INTERVAL + 10) tick();
      set_modes(M_BADCHK, M_BADCHK, M_BADCHK);
      request(5000, 1'b1, d, st, ca, acc, rc, seen);
      n  = pulse_q.size() - base_idx;
      g0 = (n == 3) ? pulse_q[base_idx + 1] - pulse_q[base_idx] : 0;
      g1 = (n == 3) ? pulse_q[base_idx + 2] - pulse_q[base_idx + 1] : 0;
      check("t2_seen", seen, 1);
      check("t2_starts", n, 3);
      check("t2_gap0_in_range", (g0 >= MIN_INTERVAL) && (g0 <= MIN_INTERVAL + 1), 1);
      check("t2_gap1_in_range", (g1 >= MIN_INTERVAL) && (g1 <= MIN_INTERVAL + 1), 1);
      check("t2_status", st, 2'b01);
      check("t2_data", d, 0);

      // 3: hold never rises
      repeat (MIN_INTERVAL + 10) tick();
      set_modes(M_NOHOLD, M_NOHOLD, M_NOHOLD);
      request(5000, 1'b1, d, st, ca, acc, rc, seen);
      n = pulse_q.size() - base_idx;
      check("t3_seen", seen, 1);
      check("t3_starts", n, 3);
      check("t3_status", st, 2'b10);
      check("t3_data", d, 0);
      // Failure is decided on the 8th cycle after the pulse; the response shows the cycle after.
      check("t3_arm_fail_latency", (n >= 1) ? rc - pulse_q[pulse_q.size() - 1] : -1, ARM_WINDOW + 1);

      // 4: all-zero frame, then a good frame
      repeat (MIN_INTERVAL + 10) tick();
      set_modes(M_ZERO, M_GOOD, M_GOOD);
      request(5000, 1'b1, d, st, ca, acc, rc, seen);
      n = pulse_q.size() - base_idx;
      check("t4_seen", seen, 1);
      check("t4_starts", n, 2);
      check("t4_status", st, 2'b00);
      check("t4_data", d, 32'h37001800);

      // 5: early request 200 cycles after a good response
      prev = pulse_q[pulse_q.size() - 1];
      repeat (200) tick();
      set_modes(M_GOOD, M_GOOD, M_GOOD);
      request(5000, 1'b1, d, st, ca, acc, rc, seen);
      n = pulse_q.size() - base_idx;
      check("t5_seen", seen, 1);
      check("t5_data", d, 32'h37001800);
      check("t5_status", st, 2'b00);
`ifdef SENSOR_CACHE_EN
      check("t5_cached", ca, 1);
      check("t5_cached_latency", rc - acc, 1);
      check("t5_no_start", n, 0);
`else
      check("t5_cached", ca, 0);
      check("t5_starts", n, 1);
      g0 = (n >= 1) ? pulse_q[base_idx] - prev : 0;
      check("t5_gap_in_range", (g0 >= MIN_INTERVAL) && (g0 <= MIN_INTERVAL + 1), 1);
`endif

      // 6: reset while BUSY, then a stalled response
      repeat (MIN_INTERVAL + 10) tick();
      set_modes(M_GOOD, M_GOOD, M_GOOD);
      n = 0;
      while (req_ready !== 1'b1 && n < 100) begin tick(); n++; end
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (20) tick();
      reset = 1'b1;
      tick();
      check("t6_rst_req_ready", req_ready, 0);
      check("t6_rst_rsp_valid", rsp_valid, 0);
      check("t6_rst_rsp_data", rsp_data, 0);
      check("t6_rst_rsp_status", rsp_status, 0);
      check("t6_rst_dec_reset", dec_reset, 0);
      check("t6_rst_dec_enable", dec_enable, 0);
      reset = 1'b0;
      n0 = pulse_q.size();
      n  = 0;
      while (model_busy && n < 300) begin tick(); n++; end
      repeat (5) tick();
      check("t6_no_restart", pulse_q.size(), n0);
      check("t6_idle_ready", req_ready, 1);

      set_modes(M_GOOD, M_GOOD, M_GOOD);
      request(5000, 1'b0, d, st, ca, acc, rc, seen);
      n = pulse_q.size() - base_idx;
      check("t6_seen", seen, 1);
      check("t6_start_latency", (n >= 1) ? pulse_q[base_idx] - acc : -1, 1);
      check("t6_data", d, 32'h37001800);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_status !== st) bad++;
      end
      check("t6_stall_stable", bad, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      tick();
      check("t6_released", rsp_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
